serial_add_ctrl: RTL and testbench

//  Bit-serial add controller that time-multiplexes one external add_full cell
//  to add two WIDTH-bit operands, LSB first, one bit per clock.

---
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller: drives one external add_full cell LSB first, one bit per clock.
// Optional SERIAL_ADD_SUB_EN adds a sub input for two's-complement subtraction.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic             sub_q;
    logic             sub_in;
    logic             last_bit;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign last_bit = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Adder inputs are gated so the shared cell sees zeros outside RUN.
    always_comb begin
        busy   = (state_q == StRun);
        fa_a   = busy & a_sh_q[0];
        fa_b   = busy & (b_sh_q[0] ^ sub_q);
        fa_cin = busy & carry_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            result   <= '0;
            c_out    <= 1'b0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_sh_q   <= op_a;
                        b_sh_q   <= op_b;
                        sum_sh_q <= '0;
                        cnt_q    <= '0;
                        // Subtraction is a + ~b + 1: the +1 enters as the first carry.
                        carry_q  <= sub_in;
                        sub_q    <= sub_in;
                        result   <= '0;
                        c_out    <= 1'b0;
                        ovf      <= 1'b0;
                    end
                end
                StRun: begin
                    sum_sh_q <= {fa_sum, sum_sh_q[WIDTH-1:1]};
                    carry_q  <= fa_cout;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + CntOne;
                    if (last_bit) begin
                        result <= {fa_sum, sum_sh_q[WIDTH-1:1]};
                        c_out  <= fa_cout;
                        ovf    <= fa_cin ^ fa_cout;
                        done   <= 1'b1;
                    end
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural add_full cell on the fa_* ports.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic         busy, done, c_out, ovf;
    logic [W-1:0] result;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub),
`endif
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .c_out   (c_out),
        .ovf     (ovf)
    );

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_not_busy", 32'(busy), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 result=0x%0h, required no done", result);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", 32'(result), 32'(mon_e.res));
                check("c_out", 32'(c_out), 32'(mon_e.co));
                check("ovf", 32'(ovf), 32'(mon_e.ov));
            end
        end
    end

    task automatic set_sub(input logic s);
`ifdef SERIAL_ADD_SUB_EN
        sub = s;
`else
        if (s) $display("note: sub request ignored in add-only build");
`endif
    endtask

    task automatic wait_done_and_idle();
        repeat (W) @(posedge clk);
        #1;
        check("done_latency", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_fa_zero", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input exp_t e);
        @(posedge clk);
        #1;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        set_sub(s);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (W - 1) @(posedge clk);
        #1;
        check("busy_before_done", 32'(busy), 32'd1);
        // Already W-1 edges in; wait_done_and_idle expects to start just after accept.
        exp_q.push_back(exp_t'(0));
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        check("done_latency", 32'(done), 32'd1);
        check("busy_low_in_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_fa_zero", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        set_sub(1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);

        run_op(8'h12, 8'h34, 1'b0, '{res: 8'h46, co: 1'b0, ov: 1'b0});
        run_op(8'hFF, 8'h01, 1'b0, '{res: 8'h00, co: 1'b1, ov: 1'b0});
        run_op(8'h7F, 8'h01, 1'b0, '{res: 8'h80, co: 1'b0, ov: 1'b1});
        check("result_held", 32'(result), 32'h80);

        // start held high across RUN and DONE: only one op may be taken.
        @(posedge clk);
        #1;
        start = 1'b1;
        op_a  = 8'h0F;
        op_b  = 8'h01;
        exp_q.push_back('{res: 8'h10, co: 1'b0, ov: 1'b0});
        repeat (W + 2) @(posedge clk);
        #1;
        check("idle_after_held_start", 32'(busy), 32'd0);
        op_a = 8'h80;
        op_b = 8'h80;
        exp_q.push_back('{res: 8'h00, co: 1'b1, ov: 1'b1});
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_in_idle_after_done", 32'(busy), 32'd1);
        wait_done_and_idle();

        // Reset in the middle of RUN discards the op.
        @(posedge clk);
        #1;
        start = 1'b1;
        op_a  = 8'hAA;
        op_b  = 8'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        repeat (W + 2) @(posedge clk);
        #1;
        check("abort_no_done", 32'(exp_q.size()), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, '{res: 8'h02, co: 1'b0, ov: 1'b0});

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, '{res: 8'hFE, co: 1'b0, ov: 1'b0});
        run_op(8'h80, 8'h01, 1'b1, '{res: 8'h7F, co: 1'b1, ov: 1'b1});
        run_op(8'h12, 8'h34, 1'b0, '{res: 8'h46, co: 1'b0, ov: 1'b0});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("no_pending_expect", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
